// File: rtl/cv32e40s_pkg.sv
// Shared types for the hazard scoreboard: the in-flight write entry and default sizing.
package cv32e40s_pkg;

  localparam int SB_DEPTH_DEFAULT = 4;
  localparam int SB_ADDR_W        = 5;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] waddr;
    logic                 we;
    logic                 committed;
  } sb_entry_t;

endpackage

// File: rtl/cv32e40s_hazard_scoreboard_sva.sv
// Protocol checker for the hazard scoreboard, attached to every instance by bind.
module cv32e40s_hazard_scoreboard_sva #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             rst_n,
  input logic             retire_i,
  input logic             issue_valid_i,
  input logic             issue_ready_o,
  input logic             empty_o,
  input logic             full_o,
  input logic [CNT_W-1:0] count_o,
  input logic             head_committed
);

  a_no_retire_empty: assert property (@(posedge clk) disable iff (!rst_n)
    retire_i |-> (!empty_o && head_committed));

  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    int'(count_o) <= DEPTH);

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    (issue_valid_i && issue_ready_o) |-> !full_o);

endmodule

bind cv32e40s_hazard_scoreboard cv32e40s_hazard_scoreboard_sva #(
  .DEPTH (DEPTH),
  .CNT_W (CNT_W)
) u_sva (
  .clk            (clk),
  .rst_n          (rst_n),
  .retire_i       (retire_i),
  .issue_valid_i  (issue_valid_i),
  .issue_ready_o  (issue_ready_o),
  .empty_o        (empty_o),
  .full_o         (full_o),
  .count_o        (count_o),
  .head_committed (head_committed_s)
);

// File: rtl/cv32e40s_sb_match.sv
// Compares one ID read address against every live scoreboard entry.
// x0 and disabled read ports never report a hit.
module cv32e40s_sb_match
  import cv32e40s_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH_DEFAULT,
  parameter int ADDR_W = SB_ADDR_W
) (
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  sb_entry_t         entries [DEPTH],
  input  logic [DEPTH-1:0]  live,
  output logic              hit
);

  logic any_match_s;

  // OR-reduce address matches over entries that write the register file
  always_comb begin
    any_match_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_match_s = any_match_s | (live[i] & entries[i].we & (entries[i].waddr == raddr));
    end
    hit = re & (raddr != {ADDR_W{1'b0}}) & any_match_s;
  end

endmodule

// File: rtl/cv32e40s_hazard_scoreboard.sv
// In-order queue of in-flight register writes (issue -> commit -> retire) that
// flags RAW hazards per ID read port and stalls ID on a hazard or a full queue.
module cv32e40s_hazard_scoreboard
  import cv32e40s_pkg::*;
#(
  parameter int NUM_READ_PORTS = 2,
  parameter int DEPTH          = SB_DEPTH_DEFAULT,
  parameter int ADDR_W         = SB_ADDR_W,
  parameter int BYPASS_EN      = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             issue_valid_i,
  input  logic                             issue_we_i,
  input  logic [ADDR_W-1:0]                issue_waddr_i,
  output logic                             issue_ready_o,
  input  logic                             commit_i,
  input  logic                             retire_i,
  input  logic                             kill_i,
  input  logic [NUM_READ_PORTS-1:0]        rf_re_i,
  input  logic [NUM_READ_PORTS*ADDR_W-1:0] rf_raddr_i,
  output logic [NUM_READ_PORTS-1:0]        hazard_o,
  output logic                             stall_o,
  output logic [$clog2(DEPTH+1)-1:0]       count_o,
  output logic                             empty_o,
  output logic                             full_o
);

  localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W    = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH-1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

  sb_entry_t          entry_r [DEPTH];
  sb_entry_t          entry_s [DEPTH];
  logic [DEPTH-1:0]   valid_r, valid_s, live_s;
  logic [PTR_W-1:0]   head_r, head_s, tail_r, tail_s, cptr_r, cptr_s;
  logic [CNT_W-1:0]   count_r, count_s, ccount_r, ccount_s;
  logic               full_s, empty_s, push_s, pop_s, commit_s, head_committed_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Committed entries always form a prefix starting at head; ccount tracks its length.
  assign full_s           = (count_r == CNT_FULL);
  assign empty_s          = (count_r == {CNT_W{1'b0}});
  assign head_committed_s = entry_r[head_r].committed;
  assign push_s           = issue_valid_i & ~full_s & ~kill_i;
  assign pop_s            = retire_i & ~empty_s & head_committed_s;
  assign commit_s         = commit_i & (ccount_r != count_r);

  // Next queue state: commit and retire first, then either kill or push
  always_comb begin
    entry_s  = entry_r;
    valid_s  = valid_r;
    head_s   = head_r;
    tail_s   = tail_r;
    cptr_s   = cptr_r;
    count_s  = count_r;
    ccount_s = ccount_r + CNT_W'(commit_s) - CNT_W'(pop_s);
    if (commit_s) begin
      entry_s[cptr_r].committed = 1'b1;
      cptr_s                    = ptr_inc(cptr_r);
    end else begin
      cptr_s = cptr_r;
    end
    if (pop_s) begin
      valid_s[head_r] = 1'b0;
      head_s          = ptr_inc(head_r);
    end else begin
      head_s = head_r;
    end
    if (kill_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_s[i] = valid_s[i] & entry_s[i].committed;
      end
      tail_s  = cptr_s;
      count_s = ccount_s;
    end else if (push_s) begin
      entry_s[tail_r].waddr     = issue_waddr_i;
      entry_s[tail_r].we        = issue_we_i;
      entry_s[tail_r].committed = 1'b0;
      valid_s[tail_r]           = 1'b1;
      tail_s                    = ptr_inc(tail_r);
      count_s                   = count_r + CNT_W'(1) - CNT_W'(pop_s);
    end else begin
      tail_s  = tail_r;
      count_s = count_r - CNT_W'(pop_s);
    end
  end

  // Queue state register with synchronous reset that drops every entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_r[i] <= '0;
      end
      valid_r  <= {DEPTH{1'b0}};
      head_r   <= {PTR_W{1'b0}};
      tail_r   <= {PTR_W{1'b0}};
      cptr_r   <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      ccount_r <= {CNT_W{1'b0}};
    end else begin
      entry_r  <= entry_s;
      valid_r  <= valid_s;
      head_r   <= head_s;
      tail_r   <= tail_s;
      cptr_r   <= cptr_s;
      count_r  <= count_s;
      ccount_r <= ccount_s;
    end
  end

  // Entries visible to hazard matching; the retiring head is bypassed when enabled
  always_comb begin
    live_s = valid_r;
    if ((BYPASS_EN != 0) && pop_s) begin
      live_s[head_r] = 1'b0;
    end else begin
      live_s = valid_r;
    end
  end

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_match
    cv32e40s_sb_match #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_match (
      .re      (rf_re_i[p]),
      .raddr   (rf_raddr_i[p*ADDR_W +: ADDR_W]),
      .entries (entry_r),
      .live    (live_s),
      .hit     (hazard_o[p])
    );
  end

  assign issue_ready_o = ~full_s;
  assign stall_o       = (|hazard_o) | (issue_valid_i & full_s);
  assign count_o       = count_r;
  assign empty_o       = empty_s;
  assign full_o        = full_s;

endmodule

// File: tb/tb_cv32e40s_hazard_scoreboard.sv
// Scoreboard bench: instance A (DEPTH=4, bypass on) and instance B (DEPTH=3, bypass off).
module tb_cv32e40s_hazard_scoreboard;

  typedef struct {
    string      name;
    logic [1:0] hz;
    logic       st;
    logic [2:0] cnt;
    logic       em;
    logic       fu;
    logic       rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_iv = 1'b0, a_we = 1'b0, a_cm = 1'b0, a_rt = 1'b0, a_kl = 1'b0;
  logic [4:0] a_wa = 5'd0;
  logic [1:0] a_re = 2'b00;
  logic [9:0] a_ra = 10'd0;
  logic [1:0] a_hazard;
  logic       a_ready, a_stall, a_empty, a_full;
  logic [2:0] a_count;

  logic       b_iv = 1'b0, b_we = 1'b0, b_cm = 1'b0, b_rt = 1'b0, b_kl = 1'b0;
  logic [4:0] b_wa = 5'd0;
  logic [1:0] b_re = 2'b00;
  logic [9:0] b_ra = 10'd0;
  logic [1:0] b_hazard;
  logic       b_ready, b_stall, b_empty, b_full;
  logic [1:0] b_count;

  cv32e40s_hazard_scoreboard #(.NUM_READ_PORTS(2), .DEPTH(4), .ADDR_W(5), .BYPASS_EN(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .issue_valid_i(a_iv), .issue_we_i(a_we), .issue_waddr_i(a_wa),
    .issue_ready_o(a_ready), .commit_i(a_cm), .retire_i(a_rt), .kill_i(a_kl),
    .rf_re_i(a_re), .rf_raddr_i(a_ra), .hazard_o(a_hazard), .stall_o(a_stall),
    .count_o(a_count), .empty_o(a_empty), .full_o(a_full));

  cv32e40s_hazard_scoreboard #(.NUM_READ_PORTS(2), .DEPTH(3), .ADDR_W(5), .BYPASS_EN(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .issue_valid_i(b_iv), .issue_we_i(b_we), .issue_waddr_i(b_wa),
    .issue_ready_o(b_ready), .commit_i(b_cm), .retire_i(b_rt), .kill_i(b_kl),
    .rf_re_i(b_re), .rf_raddr_i(b_ra), .hazard_o(b_hazard), .stall_o(b_stall),
    .count_o(b_count), .empty_o(b_empty), .full_o(b_full));

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   errors = 0;
  int   checks = 0;

  task automatic compare(input exp_t e, input logic [1:0] hz, input logic st, input logic [2:0] cnt,
                         input logic em, input logic fu, input logic rd);
    checks++;
    if (hz !== e.hz || st !== e.st || cnt !== e.cnt || em !== e.em || fu !== e.fu || rd !== e.rd) begin
      errors++;
      $display("FAIL %s: got hz=%b st=%b cnt=%0d em=%b fu=%b rd=%b, want hz=%b st=%b cnt=%0d em=%b fu=%b rd=%b",
               e.name, hz, st, cnt, em, fu, rd, e.hz, e.st, e.cnt, e.em, e.fu, e.rd);
    end
  endtask

  // Monitor: outputs are combinational, so each cycle's expectation is checked mid-cycle
  always @(negedge clk) begin
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      compare(ea, a_hazard, a_stall, a_count, a_empty, a_full, a_ready);
    end
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      compare(eb, b_hazard, b_stall, {1'b0, b_count}, b_empty, b_full, b_ready);
    end
  end

  // One cycle of stimulus on DUT sel (0=A, 1=B) plus its expected outputs
  task automatic step(input bit sel, input string nm, input logic iv, input logic we, input logic [4:0] wa,
                      input logic cm, input logic rt, input logic kl, input logic [1:0] re,
                      input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] hz, input logic st,
                      input logic [2:0] cnt, input logic em, input logic fu);
    exp_t e;
    e.name = nm; e.hz = hz; e.st = st; e.cnt = cnt; e.em = em; e.fu = fu; e.rd = ~fu;
    if (sel == 1'b0) begin
      a_iv = iv; a_we = we; a_wa = wa; a_cm = cm; a_rt = rt; a_kl = kl; a_re = re; a_ra = {r1, r0};
      qa.push_back(e);
    end else begin
      b_iv = iv; b_we = we; b_wa = wa; b_cm = cm; b_rt = rt; b_kl = kl; b_re = re; b_ra = {r1, r0};
      qb.push_back(e);
    end
    @(posedge clk);
    #1;
    a_iv = 1'b0; a_cm = 1'b0; a_rt = 1'b0; a_kl = 1'b0; a_re = 2'b00;
    b_iv = 1'b0; b_cm = 1'b0; b_rt = 1'b0; b_kl = 1'b0; b_re = 2'b00;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    //        sel name               iv we wa    cm rt kl re     r0     r1     hz     st cnt  em fu
    step(1'b0, "a_reset",           0, 0, 5'd0, 0, 0, 0, 2'b01, 5'd5,  5'd0,  2'b00, 0, 3'd0, 1, 0);
    step(1'b0, "a_issue_x5",        1, 1, 5'd5, 0, 0, 0, 2'b00, 5'd0,  5'd0,  2'b00, 0, 3'd0, 1, 0);
    step(1'b0, "a_raw_port1",       0, 0, 5'd0, 0, 0, 0, 2'b10, 5'd0,  5'd5,  2'b10, 1, 3'd1, 0, 0);
    step(1'b0, "a_commit_x5",       0, 0, 5'd0, 1, 0, 0, 2'b10, 5'd0,  5'd5,  2'b10, 1, 3'd1, 0, 0);
    step(1'b0, "a_retire_bypass",   0, 0, 5'd0, 0, 1, 0, 2'b10, 5'd0,  5'd5,  2'b00, 0, 3'd1, 0, 0);
    step(1'b0, "a_after_retire",    0, 0, 5'd0, 0, 0, 0, 2'b10, 5'd0,  5'd5,  2'b00, 0, 3'd0, 1, 0);
    step(1'b0, "a_issue_x0",        1, 1, 5'd0, 0, 0, 0, 2'b00, 5'd0,  5'd0,  2'b00, 0, 3'd0, 1, 0);
    step(1'b0, "a_read_x0",         0, 0, 5'd0, 0, 0, 0, 2'b11, 5'd0,  5'd0,  2'b00, 0, 3'd1, 0, 0);
    step(1'b0, "a_issue_x7",        1, 1, 5'd7, 0, 0, 0, 2'b00, 5'd0,  5'd0,  2'b00, 0, 3'd1, 0, 0);
    step(1'b0, "a_issue_x8",        1, 1, 5'd8, 0, 0, 0, 2'b00, 5'd0,  5'd0,  2'b00, 0, 3'd2, 0, 0);
    step(1'b0, "a_issue_x9",        1, 1, 5'd9, 0, 0, 0, 2'b00, 5'd0,  5'd0,  2'b00, 0, 3'd3, 0, 0);
    step(1'b0, "a_full",            0, 0, 5'd0, 0, 0, 0, 2'b01, 5'd9,  5'd0,  2'b01, 1, 3'd4, 0, 1);
    step(1'b0, "a_full_issue",      1, 1, 5'd10,0, 0, 0, 2'b00, 5'd0,  5'd0,  2'b00, 1, 3'd4, 0, 1);
    step(1'b0, "a_commit_x0",       0, 0, 5'd0, 1, 0, 0, 2'b00, 5'd0,  5'd0,  2'b00, 0, 3'd4, 0, 1);
    step(1'b0, "a_full_issue_ret",  1, 1, 5'd11,0, 1, 0, 2'b00, 5'd0,  5'd0,  2'b00, 1, 3'd4, 0, 1);
    step(1'b0, "a_count_stays3",    0, 0, 5'd0, 0, 0, 0, 2'b11, 5'd11, 5'd7,  2'b10, 1, 3'd3, 0, 0);
    step(1'b0, "a_kill_drop_push",  1, 1, 5'd12,0, 0, 1, 2'b00, 5'd0,  5'd0,  2'b00, 0, 3'd3, 0, 0);
    step(1'b0, "a_after_kill",      0, 0, 5'd0, 0, 0, 0, 2'b11, 5'd7,  5'd12, 2'b00, 0, 3'd0, 1, 0);
    step(1'b0, "a_issue_x3",        1, 1, 5'd3, 0, 0, 0, 2'b00, 5'd0,  5'd0,  2'b00, 0, 3'd0, 1, 0);
    step(1'b0, "a_issue_x4_cm_x3",  1, 1, 5'd4, 1, 0, 0, 2'b00, 5'd0,  5'd0,  2'b00, 0, 3'd1, 0, 0);
    step(1'b0, "a_issue_x6",        1, 1, 5'd6, 0, 0, 0, 2'b00, 5'd0,  5'd0,  2'b00, 0, 3'd2, 0, 0);
    step(1'b0, "a_kill_x4_x6",      0, 0, 5'd0, 0, 0, 1, 2'b11, 5'd3,  5'd4,  2'b11, 1, 3'd3, 0, 0);
    step(1'b0, "a_kill_keeps_x3",   0, 0, 5'd0, 0, 0, 0, 2'b11, 5'd3,  5'd4,  2'b01, 1, 3'd1, 0, 0);
    step(1'b0, "a_x6_gone",         0, 0, 5'd0, 0, 0, 0, 2'b11, 5'd6,  5'd3,  2'b10, 1, 3'd1, 0, 0);
    step(1'b0, "a_commit_not_push", 1, 1, 5'd13,1, 0, 0, 2'b00, 5'd0,  5'd0,  2'b00, 0, 3'd1, 0, 0);
    step(1'b0, "a_kill_x13",        0, 0, 5'd0, 0, 0, 1, 2'b01, 5'd13, 5'd0,  2'b01, 1, 3'd2, 0, 0);
    step(1'b0, "a_x13_killed",      0, 0, 5'd0, 0, 0, 0, 2'b01, 5'd13, 5'd0,  2'b00, 0, 3'd1, 0, 0);
    step(1'b0, "a_retire_x3",       0, 0, 5'd0, 0, 1, 0, 2'b01, 5'd3,  5'd0,  2'b00, 0, 3'd1, 0, 0);
    step(1'b0, "a_empty",           0, 0, 5'd0, 0, 0, 0, 2'b01, 5'd3,  5'd0,  2'b00, 0, 3'd0, 1, 0);

    step(1'b1, "b_reset",           0, 0, 5'd0, 0, 0, 0, 2'b01, 5'd5,  5'd0,  2'b00, 0, 3'd0, 1, 0);
    step(1'b1, "b_issue_x5",        1, 1, 5'd5, 0, 0, 0, 2'b00, 5'd0,  5'd0,  2'b00, 0, 3'd0, 1, 0);
    step(1'b1, "b_raw_port1",       0, 0, 5'd0, 0, 0, 0, 2'b10, 5'd0,  5'd5,  2'b10, 1, 3'd1, 0, 0);
    step(1'b1, "b_commit_x5",       0, 0, 5'd0, 1, 0, 0, 2'b10, 5'd0,  5'd5,  2'b10, 1, 3'd1, 0, 0);
    step(1'b1, "b_retire_nobypass", 0, 0, 5'd0, 0, 1, 0, 2'b10, 5'd0,  5'd5,  2'b10, 1, 3'd1, 0, 0);
    step(1'b1, "b_cleared",         0, 0, 5'd0, 0, 0, 0, 2'b10, 5'd0,  5'd5,  2'b00, 0, 3'd0, 1, 0);
    for (int k = 1; k <= 10; k++) begin
      step(1'b1, "b_round_issue",  1, 1, 5'(k), 0, 0, 0, 2'b11, 5'(k), 5'(k-1), 2'b00, 0, 3'd0, 1, 0);
      step(1'b1, "b_round_commit", 0, 0, 5'd0,  1, 0, 0, 2'b11, 5'(k), 5'(k-1), 2'b01, 1, 3'd1, 0, 0);
      step(1'b1, "b_round_retire", 0, 0, 5'd0,  0, 1, 0, 2'b11, 5'(k), 5'(k-1), 2'b01, 1, 3'd1, 0, 0);
    end
    step(1'b1, "b_issue_nowe",      1, 0, 5'd9, 0, 0, 0, 2'b00, 5'd0,  5'd0,  2'b00, 0, 3'd0, 1, 0);
    step(1'b1, "b_nowe_read",       0, 0, 5'd0, 0, 0, 1, 2'b01, 5'd9,  5'd0,  2'b00, 0, 3'd1, 0, 0);
    step(1'b1, "b_fill_x1",         1, 1, 5'd1, 0, 0, 0, 2'b00, 5'd0,  5'd0,  2'b00, 0, 3'd0, 1, 0);
    step(1'b1, "b_fill_x2",         1, 1, 5'd2, 0, 0, 0, 2'b00, 5'd0,  5'd0,  2'b00, 0, 3'd1, 0, 0);
    step(1'b1, "b_fill_x3",         1, 1, 5'd3, 0, 0, 0, 2'b00, 5'd0,  5'd0,  2'b00, 0, 3'd2, 0, 0);
    step(1'b1, "b_full",            0, 0, 5'd0, 0, 0, 0, 2'b11, 5'd3,  5'd1,  2'b11, 1, 3'd3, 0, 1);
    step(1'b1, "b_full_issue",      1, 1, 5'd4, 0, 0, 0, 2'b00, 5'd0,  5'd0,  2'b00, 1, 3'd3, 0, 1);
    step(1'b1, "b_kill_all",        0, 0, 5'd0, 0, 0, 1, 2'b00, 5'd0,  5'd0,  2'b00, 0, 3'd3, 0, 1);
    step(1'b1, "b_drained",         0, 0, 5'd0, 0, 0, 0, 2'b01, 5'd4,  5'd0,  2'b00, 0, 3'd0, 1, 0);

    @(negedge clk);
    #1;
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: pending a=%0d b=%0d, want 0 0", qa.size(), qb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
